// File: rtl/timer_pkg.sv
// timer_pkg: edge modes, clock selects, control bit positions and FSM states shared by the timer blocks
package timer_pkg;
  localparam logic [1:0] PROHIBITED = 2'b00, RISING_EDGE = 2'b01, FALLING_EDGE = 2'b10, BOTH_EDGES = 2'b11;
  localparam logic [2:0] CS_STOP = 3'd0, CS_DIV1 = 3'd1, CS_DIV8 = 3'd2, CS_DIV64 = 3'd3;
  localparam logic [2:0] CS_DIV256 = 3'd4, CS_DIV1024 = 3'd5, CS_EXT = 3'd6, CS_RSVD = 3'd7;
  localparam int CTRL_EN = 0, CTRL_CS_LSB = 1, CTRL_EDGE_LSB = 4, CTRL_AUTO = 6, CTRL_CLR = 7;
  typedef enum logic [1:0] {STOPPED, CLEARING, RUNNING} state_t;
  typedef struct packed {
    logic       auto_clear;
    logic [1:0] ext_edge;
    logic [2:0] clk_sel;
    logic       enable;
  } ctrl_t;
  function automatic logic valid_src(ctrl_t c);
    return c.enable && (c.clk_sel inside {[CS_DIV1:CS_EXT]});
  endfunction
  function automatic logic [9:0] tick_mask(logic [2:0] sel);
    return sel == CS_DIV8 ? 10'h007 : sel == CS_DIV64 ? 10'h03F :
           sel == CS_DIV256 ? 10'h0FF : sel == CS_DIV1024 ? 10'h3FF : 10'h000;
  endfunction
endpackage

// File: rtl/timer_clock_ctrl_if.sv
// timer_clock_ctrl_if: control, pin and counter-side signals of the timer clock front end
interface timer_clock_ctrl_if;
  logic       CtrlWrite;
  logic [7:0] CtrlData;
  logic       FlagClear;
  logic       ExtClockIn;
  logic       Overflow;
  logic       CounterClock;
  logic [1:0] CounterEdge;
  logic       CounterClear;
  logic       OverflowFlag;
  logic       Running;
  modport master (
    output CtrlWrite, CtrlData, FlagClear, ExtClockIn, Overflow,
    input  CounterClock, CounterEdge, CounterClear, OverflowFlag, Running
  );
  modport slave (
    input  CtrlWrite, CtrlData, FlagClear, ExtClockIn, Overflow,
    output CounterClock, CounterEdge, CounterClear, OverflowFlag, Running
  );
endinterface

// File: rtl/timer_sync2.sv
// timer_sync2: two-flop synchronizer for an asynchronous input
module timer_sync2 (
  input  logic Clock,
  input  logic ResetN,
  input  logic async_in,
  output logic sync_out
);
  logic [1:0] sync_q, sync_d;
  always_comb sync_d = {sync_q[0], async_in};
  always_ff @(posedge Clock) sync_q <= !ResetN ? 2'b00 : sync_d;
  assign sync_out = sync_q[1];
endmodule

// File: rtl/timer_clock_ctrl.sv
// timer_clock_ctrl: counter clock source select, clear sequencing and sticky overflow flag
module timer_clock_ctrl
  import timer_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 10
) (
  input logic Clock,
  input logic ResetN,
  timer_clock_ctrl_if.slave bus
);
  state_t state_q, state_d;
  ctrl_t ctrl_q, ctrl_d, wr_ctrl;
  logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
  logic [1:0] edge_q, edge_d;
  logic ov_q, flag_q, flag_d, cclk_q, cclk_d, clear_q, clear_d, run_q, run_d;
  logic ext_sync, ov_rise, wr_clr, ext_src, tick, sel_chg;
  timer_sync2 u_sync (.Clock(Clock), .ResetN(ResetN), .async_in(bus.ExtClockIn), .sync_out(ext_sync));
  always_comb begin
    wr_ctrl = '{auto_clear: bus.CtrlData[CTRL_AUTO], ext_edge: bus.CtrlData[CTRL_EDGE_LSB +: 2],
                clk_sel: bus.CtrlData[CTRL_CS_LSB +: 3], enable: bus.CtrlData[CTRL_EN]};
    wr_clr = bus.CtrlWrite && bus.CtrlData[CTRL_CLR];
    ctrl_d = bus.CtrlWrite ? wr_ctrl : ctrl_q;
    ov_rise = bus.Overflow && !ov_q;
    ext_src = ctrl_q.clk_sel == CS_EXT;
    tick = &(presc_q[9:0] | ~tick_mask(ctrl_q.clk_sel));
    sel_chg = bus.CtrlWrite && wr_ctrl.clk_sel != ctrl_q.clk_sel;
    state_d = state_q;
    if (wr_clr) state_d = CLEARING;
    else if (state_q == CLEARING) state_d = valid_src(ctrl_d) ? RUNNING : STOPPED;
    else if (state_q == STOPPED && bus.CtrlWrite && valid_src(wr_ctrl)) state_d = RUNNING;
    else if (state_q == RUNNING && bus.CtrlWrite && !valid_src(wr_ctrl)) state_d = STOPPED;
    else if (state_q == RUNNING && ctrl_q.auto_clear && ov_rise) state_d = CLEARING;
    presc_d = (state_q == RUNNING && state_d == RUNNING && !sel_chg) ? presc_q + 1'b1 : '0;
    cclk_d = state_q != RUNNING ? cclk_q : ext_src ? ext_sync : cclk_q ^ tick;
    edge_d = state_q != RUNNING ? PROHIBITED : ext_src ? ctrl_q.ext_edge : BOTH_EDGES;
    clear_d = state_q == CLEARING;
    run_d = state_q == RUNNING;
    flag_d = ov_rise || (flag_q && !bus.FlagClear);
  end
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state_q <= STOPPED;
      ctrl_q  <= '0;
      presc_q <= '0;
      edge_q  <= PROHIBITED;
      ov_q    <= 1'b0;
      flag_q  <= 1'b0;
      cclk_q  <= 1'b0;
      clear_q <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      presc_q <= presc_d;
      edge_q  <= edge_d;
      ov_q    <= bus.Overflow;
      flag_q  <= flag_d;
      cclk_q  <= cclk_d;
      clear_q <= clear_d;
      run_q   <= run_d;
    end
  end
  assign bus.CounterClock = cclk_q;
  assign bus.CounterEdge  = edge_q;
  assign bus.CounterClear = clear_q;
  assign bus.OverflowFlag = flag_q;
  assign bus.Running      = run_q;
endmodule

// File: tb/tb_timer_clock_ctrl.sv
// tb_timer_clock_ctrl: randomized self-checking bench for timer_clock_ctrl
module tb_timer_clock_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int pin_min = 2, pin_max = 6, pin_left = 4;
  logic pin_auto = 1'b0;
  logic pin_hist[$];
  timer_clock_ctrl_if bus();
  timer_clock_ctrl dut (.Clock(clk), .ResetN(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic step();
    pin_hist.push_front(bus.ExtClockIn);
    if (pin_hist.size() > 8) void'(pin_hist.pop_back());
    @(posedge clk);
    #1;
    if (pin_auto) begin
      pin_left = pin_left - 1;
      if (pin_left == 0) begin
        bus.ExtClockIn = ~bus.ExtClockIn;
        pin_left = $urandom_range(pin_max, pin_min);
      end
    end
  endtask

  task automatic write(input logic [7:0] d);
    bus.CtrlWrite = 1'b1;
    bus.CtrlData = d;
    step();
    bus.CtrlWrite = 1'b0;
    bus.CtrlData = 8'h00;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.CtrlWrite = 1'b0;
    bus.CtrlData = 8'h00;
    bus.FlagClear = 1'b0;
    bus.ExtClockIn = 1'b0;
    bus.Overflow = 1'b0;
    repeat (3) step();
    checks++;
    if ({bus.CounterClock, bus.CounterEdge, bus.CounterClear, bus.OverflowFlag, bus.Running} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got clk=%b edge=%b clr=%b flag=%b run=%b, want all 0", bus.CounterClock,
               bus.CounterEdge, bus.CounterClear, bus.OverflowFlag, bus.Running);
    end
    rst_n = 1'b1;
    repeat (2) step();
    checks++;
    if ({bus.CounterClock, bus.CounterEdge, bus.CounterClear, bus.OverflowFlag, bus.Running} !== 6'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got clk=%b edge=%b clr=%b flag=%b run=%b, want all 0", bus.CounterClock,
               bus.CounterEdge, bus.CounterClear, bus.OverflowFlag, bus.Running);
    end
  endtask

  task automatic test_div1();
    logic base, exp;
    int toggles = 0;
    logic prev;
    write(8'h03);
    checks++;
    if (bus.Running !== 1'b0) begin
      errors++;
      $display("FAIL div1_run_latency: got %b want 0 on write edge", bus.Running);
    end
    base = bus.CounterClock;
    prev = base;
    for (int i = 1; i <= 16; i++) begin
      step();
      if (i == 1) begin
        checks++;
        if (bus.Running !== 1'b1 || bus.CounterEdge !== 2'b11) begin
          errors++;
          $display("FAIL div1_start: got run=%b edge=%b want run=1 edge=11", bus.Running, bus.CounterEdge);
        end
      end
      exp = base ^ ((i % 2) == 1);
      checks++;
      if (bus.CounterClock !== exp) begin
        errors++;
        $display("FAIL div1_clock step %0d: got %b want %b", i, bus.CounterClock, exp);
      end
      if (bus.CounterClock !== prev) toggles++;
      prev = bus.CounterClock;
    end
    checks++;
    if (toggles != 16) begin
      errors++;
      $display("FAIL div1_toggle_count: got %0d want 16", toggles);
    end
  endtask

  task automatic test_div8();
    logic base, exp, prev;
    int toggles = 0, last = 0;
    write(8'h05);
    base = bus.CounterClock;
    prev = base;
    for (int i = 1; i <= 64; i++) begin
      step();
      exp = base ^ (((i / 8) % 2) == 1);
      checks++;
      if (bus.CounterClock !== exp) begin
        errors++;
        $display("FAIL div8_clock step %0d: got %b want %b", i, bus.CounterClock, exp);
      end
      if (bus.CounterClock !== prev) begin
        toggles++;
        checks++;
        if (i - last != 8) begin
          errors++;
          $display("FAIL div8_spacing at step %0d: got gap %0d want 8", i, i - last);
        end
        last = i;
      end
      prev = bus.CounterClock;
    end
    checks++;
    if (toggles != 8) begin
      errors++;
      $display("FAIL div8_toggle_count: got %0d want 8", toggles);
    end
  endtask

  task automatic test_external();
    bus.ExtClockIn = 1'b0;
    pin_min = 4;
    pin_max = 4;
    pin_left = 4;
    pin_auto = 1'b1;
    write(8'h2D);
    for (int i = 1; i <= 80; i++) begin
      if (i == 41) begin
        pin_min = 2;
        pin_max = 6;
      end
      step();
      checks++;
      if (bus.CounterClock !== pin_hist[2] || bus.CounterEdge !== 2'b10) begin
        errors++;
        $display("FAIL ext_track step %0d: got clk=%b edge=%b want clk=%b edge=10", i, bus.CounterClock,
                 bus.CounterEdge, pin_hist[2]);
      end
    end
    write(8'h0D);
    step();
    checks++;
    if (bus.CounterEdge !== 2'b00 || bus.Running !== 1'b1 || bus.CounterClock !== pin_hist[2]) begin
      errors++;
      $display("FAIL ext_edge_none: got edge=%b run=%b clk=%b want edge=00 run=1 clk=%b", bus.CounterEdge,
               bus.Running, bus.CounterClock, pin_hist[2]);
    end
    pin_auto = 1'b0;
  endtask

  task automatic test_overflow();
    write(8'h43);
    repeat (2) step();
    checks++;
    if (bus.OverflowFlag !== 1'b0) begin
      errors++;
      $display("FAIL ovf_flag_idle: got %b want 0", bus.OverflowFlag);
    end
    bus.Overflow = 1'b1;
    step();
    checks++;
    if (bus.OverflowFlag !== 1'b1 || bus.CounterClear !== 1'b0) begin
      errors++;
      $display("FAIL ovf_flag_set: got flag=%b clr=%b want flag=1 clr=0", bus.OverflowFlag, bus.CounterClear);
    end
    step();
    checks++;
    if (bus.CounterClear !== 1'b1 || bus.Running !== 1'b0) begin
      errors++;
      $display("FAIL ovf_autoclear: got clr=%b run=%b want clr=1 run=0", bus.CounterClear, bus.Running);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (bus.CounterClear !== 1'b0 || bus.Running !== 1'b1 || bus.OverflowFlag !== 1'b1) begin
        errors++;
        $display("FAIL ovf_after_clear step %0d: got clr=%b run=%b flag=%b want 0 1 1", i, bus.CounterClear,
                 bus.Running, bus.OverflowFlag);
      end
    end
    bus.Overflow = 1'b0;
    repeat (2) step();
    bus.FlagClear = 1'b1;
    step();
    bus.FlagClear = 1'b0;
    checks++;
    if (bus.OverflowFlag !== 1'b0) begin
      errors++;
      $display("FAIL flag_clear: got %b want 0", bus.OverflowFlag);
    end
    bus.Overflow = 1'b1;
    bus.FlagClear = 1'b1;
    step();
    bus.FlagClear = 1'b0;
    checks++;
    if (bus.OverflowFlag !== 1'b1) begin
      errors++;
      $display("FAIL flag_set_wins: got %b want 1", bus.OverflowFlag);
    end
    repeat (3) step();
  endtask

  task automatic test_flag_random();
    logic exp, prev, ov, fc;
    write(8'h03);
    bus.Overflow = 1'b0;
    bus.FlagClear = 1'b1;
    repeat (2) step();
    bus.FlagClear = 1'b0;
    exp = 1'b0;
    prev = 1'b0;
    for (int i = 0; i < 60; i++) begin
      ov = 1'($urandom_range(1, 0));
      fc = ($urandom_range(3, 0) == 0);
      bus.Overflow = ov;
      bus.FlagClear = fc;
      step();
      if (ov && !prev) exp = 1'b1;
      else if (fc) exp = 1'b0;
      prev = ov;
      checks++;
      if (bus.OverflowFlag !== exp) begin
        errors++;
        $display("FAIL flag_random step %0d: got %b want %b", i, bus.OverflowFlag, exp);
      end
    end
    bus.Overflow = 1'b0;
    bus.FlagClear = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_clear_cmd();
    logic base, exp;
    int pulses = 0;
    write(8'h05);
    repeat ($urandom_range(12, 3)) step();
    write(8'h85);
    step();
    checks++;
    if (bus.CounterClear !== 1'b1 || bus.Running !== 1'b0) begin
      errors++;
      $display("FAIL clrcmd_pulse: got clr=%b run=%b want clr=1 run=0", bus.CounterClear, bus.Running);
    end
    base = bus.CounterClock;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (bus.CounterClear === 1'b1) pulses++;
      exp = base ^ (((i / 8) % 2) == 1);
      checks++;
      if (bus.CounterClock !== exp || bus.Running !== 1'b1) begin
        errors++;
        $display("FAIL clrcmd_restart step %0d: got clk=%b run=%b want clk=%b run=1", i, bus.CounterClock,
                 bus.Running, exp);
      end
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL clrcmd_single: got %0d extra pulses want 0", pulses);
    end
    write(8'h83);
    step();
    checks++;
    if (bus.CounterClear !== 1'b1 || bus.Running !== 1'b0) begin
      errors++;
      $display("FAIL clrcmd83_pulse: got clr=%b run=%b want clr=1 run=0", bus.CounterClear, bus.Running);
    end
    step();
    checks++;
    if (bus.CounterClear !== 1'b0 || bus.Running !== 1'b1) begin
      errors++;
      $display("FAIL clrcmd83_after: got clr=%b run=%b want clr=0 run=1", bus.CounterClear, bus.Running);
    end
    write(8'h00);
    step();
    checks++;
    if (bus.Running !== 1'b0 || bus.CounterEdge !== 2'b00) begin
      errors++;
      $display("FAIL stop: got run=%b edge=%b want run=0 edge=00", bus.Running, bus.CounterEdge);
    end
    base = bus.CounterClock;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (bus.CounterClock !== base) begin
        errors++;
        $display("FAIL stop_frozen step %0d: got %b want %b", i, bus.CounterClock, base);
      end
    end
  endtask

  task automatic test_reset_in_clear();
    write(8'h03);
    repeat (2) step();
    write(8'h83);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if ({bus.CounterClock, bus.CounterEdge, bus.CounterClear, bus.OverflowFlag, bus.Running} !== 6'b0) begin
      errors++;
      $display("FAIL reset_in_clear: got clk=%b edge=%b clr=%b flag=%b run=%b, want all 0", bus.CounterClock,
               bus.CounterEdge, bus.CounterClear, bus.OverflowFlag, bus.Running);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (bus.CounterClear !== 1'b0 || bus.Running !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_pulse step %0d: got clr=%b run=%b want 0 0", i, bus.CounterClear, bus.Running);
      end
    end
  endtask

  task automatic test_random_sources();
    logic [2:0] sel, cur_sel;
    logic [1:0] edg, exp_edge;
    logic en, valid, base, exp;
    int p, len;
    cur_sel = 3'd0;
    pin_min = 2;
    pin_max = 6;
    for (int it = 0; it < 14; it++) begin
      do sel = 3'($urandom_range(7, 0)); while (sel == cur_sel);
      cur_sel = sel;
      en = ($urandom_range(4, 0) != 0);
      edg = 2'($urandom_range(3, 0));
      valid = en && sel >= 3'd1 && sel <= 3'd6;
      p = sel == 3'd1 ? 1 : sel == 3'd2 ? 8 : sel == 3'd3 ? 64 : sel == 3'd4 ? 256 : 1024;
      len = !valid || sel == 3'd6 ? 40 : p <= 64 ? 2 * p + 3 : 300;
      exp_edge = !valid ? 2'b00 : sel == 3'd6 ? edg : 2'b11;
      pin_auto = valid && sel == 3'd6;
      write({2'b00, edg, sel, en});
      base = bus.CounterClock;
      for (int i = 1; i <= len; i++) begin
        step();
        if (i == 1) begin
          checks++;
          if (bus.Running !== valid || bus.CounterEdge !== exp_edge) begin
            errors++;
            $display("FAIL rand_mode it %0d data %h: got run=%b edge=%b want run=%b edge=%b", it,
                     {2'b00, edg, sel, en}, bus.Running, bus.CounterEdge, valid, exp_edge);
          end
        end
        exp = !valid ? base : sel == 3'd6 ? pin_hist[2] : base ^ (((i / p) % 2) == 1);
        checks++;
        if (bus.CounterClock !== exp) begin
          errors++;
          $display("FAIL rand_clock it %0d sel %0d step %0d: got %b want %b", it, sel, i, bus.CounterClock, exp);
        end
      end
    end
    pin_auto = 1'b0;
  endtask

  initial begin
    test_reset();
    test_div1();
    test_div8();
    test_external();
    test_overflow();
    test_flag_random();
    test_clear_cmd();
    test_reset_in_clear();
    test_random_sources();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/timer_clock_ctrl.md
# timer_clock_ctrl

Clock-source and control front end for the 8-bit timer: generates the `CounterClock`, `CounterEdge` and `CounterClear` inputs that drive the counter, and consumes its `Overflow` output. It selects between a prescaled system clock and a synchronized external pin, and sequences clear/restart. It also latches a sticky overflow flag for the interrupt logic.

## Interface
- `PRESCALE_WIDTH`, 10, prescaler counter width; must be ≥10 to support /1024.
- `Clock`  in  1  system clock; all logic on its rising edge.
- `ResetN`  in  1  synchronous, active-low reset.
- `CtrlWrite`  in  1  one-cycle strobe; loads `CtrlData`.
- `CtrlData`  in  8  [0] Enable, [3:1] ClockSelect, [5:4] ExtEdge, [6] AutoClear, [7] ClearCmd (self-clearing, not stored).
- `FlagClear`  in  1  clears `OverflowFlag`.
- `ExtClockIn`  in  1  asynchronous external count pin.
- `Overflow`  in  1  from counter; level, high while count = 8'hFF.
- `CounterClock`  out  1  count clock to counter.
- `CounterEdge`  out  2  edge mode to counter: 00 prohibited, 01 rising, 10 falling, 11 both.
- `CounterClear`  out  1  one-cycle clear pulse to counter.
- `OverflowFlag`  out  1  sticky overflow flag.
- `Running`  out  1  high in RUNNING state.

## Operation
- ClockSelect: 000 stopped; 001 /1; 010 /8; 011 /64; 100 /256; 101 /1024; 110 external; 111 reserved, treated as stopped.
- Valid source: Enable=1 and ClockSelect ∈ {001..110}.
- Internal source: prescaler increments every cycle in RUNNING. Tick when low k bits are all ones (k = 0, 3, 6, 8, 10).
  - Each tick toggles `CounterClock`.
  - `CounterEdge`=11 (both), so exactly one count per tick.
- External source: `ExtClockIn` passes through a 2-FF synchronizer; `CounterClock` = registered sync output. `CounterEdge` = ExtEdge; 00 means no counting.
- FSM states and transitions:
  - STOPPED
    - `CounterEdge`=00; `CounterClock` holds its value.
    - A write with valid source and ClearCmd=0 → RUNNING.
  - CLEARING
    - Lasts exactly one cycle; `CounterClear`=1 and prescaler zeroed.
    - Next state: RUNNING if valid source, else STOPPED.
  - RUNNING
    - A write with invalid source → STOPPED.
    - A write with ClearCmd=1 → CLEARING.
    - AutoClear=1 and rising edge of `Overflow` → CLEARING.
- ClearCmd=1 from any state → CLEARING; it has priority over all other transitions in the same cycle.
- Entering RUNNING from STOPPED zeroes the prescaler; `CounterClock` keeps its level.
- Changing ClockSelect while RUNNING (valid → valid) zeroes the prescaler and takes effect next cycle.
- `OverflowFlag`:
  - Set on rising edge of `Overflow` (current=1, previous sample=0).
  - Cleared by `FlagClear`; set wins if both happen in the same cycle.
  - Unaffected by CLEARING.

## Timing
- Reset (`ResetN`=0 at a rising edge) sets:
  - Control register to 0, state STOPPED, prescaler 0, synchronizers 0.
  - `CounterClock`=0, `CounterEdge`=00, `CounterClear`=0, `OverflowFlag`=0, `Running`=0.
- Reset mid-operation aborts CLEARING without a pulse in the following cycle.
- All outputs are registered.
- `CtrlWrite` at edge N → new state and outputs visible after edge N+1.
- Internal tick computed in cycle N → `CounterClock` toggles after edge N+1.
  - /1: toggles every cycle.
  - /8: toggles every 8 cycles.
- External latency: `ExtClockIn` change → `CounterClock` change after 3 `Clock` edges.
- `ExtClockIn` high and low phases must each be ≥2 `Clock` periods.
- `Overflow` edge → `CounterClear` high 2 cycles later (AutoClear=1); `OverflowFlag` set on the same edge.
- `CounterClear` is never high for more than 1 consecutive cycle unless ClearCmd is rewritten every cycle.

## Structure
- Shared package `timer_pkg` holds:
  - Edge constants PROHIBITED/RISING_EDGE/FALLING_EDGE/BOTH_EDGES, shared with the counter.
  - ClockSelect encodings and `CtrlData` bit positions.
  - FSM state enum.
- Sub-module `timer_sync2`: 2-flop synchronizer with synchronous active-low reset, used for `ExtClockIn`.
- Prescaler, tick select, FSM and flag logic stay in this module.

## Test plan
- Reset, then write 8'h03 (enable, /1) → `Running`=1 one cycle after the write, `CounterClock` toggles every cycle, `CounterEdge`=11; 16 cycles give 16 edges.
- Write 8'h05 (/8), run 64 cycles → exactly 8 `CounterClock` toggles spaced 8 cycles apart.
- Write 8'h2D (external, ExtEdge=10), drive `ExtClockIn` at period 8 → `CounterClock` tracks the pin 3 cycles late and `CounterEdge`=10; write 8'h0D (ExtEdge=00) → `CounterEdge`=00.
- Write 8'h43 (AutoClear, /1), raise `Overflow` → `OverflowFlag`=1 the next cycle and `CounterClear` a single pulse 2 cycles after the edge; assert `FlagClear` during a new `Overflow` rising edge → flag stays 1.
- While RUNNING, write 8'h83 → exactly one `CounterClear` pulse and prescaler restart, `Running`=0 only during that cycle. Write 8'h00 → STOPPED, `CounterEdge`=00, `CounterClock` frozen.
- Drop `ResetN` for one edge in CLEARING → all outputs 0, no further `CounterClear` pulse.
